// File: rtl/pwm_capture_if.sv
// Measurement request/result bundle between a PWM capture unit and its controller.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] window;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W-1:0] rise_cnt;
  logic [CNT_W-1:0] period;
  logic             period_valid;

  modport master (
    output start, window,
    input  busy, done, high_cnt, low_cnt, rise_cnt, period, period_valid
  );

  modport slave (
    input  start, window,
    output busy, done, high_cnt, low_cnt, rise_cnt, period, period_valid
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high/low cycles, rising edges and last full period
// of a synchronized PWM input over a programmable window of pwm_clk cycles.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | sampling s once per cycle until the window expires
// DONE  | one cycle: publish accumulators and pulse done
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic pwm_clk,
  input  logic pwm_rst,
  input  logic pwm_i,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_prev;
  logic [CNT_W-1:0]       remain;
  logic [CNT_W-1:0]       high_acc;
  logic [CNT_W-1:0]       low_acc;
  logic [CNT_W-1:0]       rise_acc;
  logic [CNT_W-1:0]       per_cnt;
  logic [CNT_W-1:0]       per_acc;

  assign s = sync_q[SYNC_STAGES-1];

  // Metastability synchronizer for the asynchronous PWM input.
  always_ff @(posedge pwm_clk or negedge pwm_rst) begin
    if (!pwm_rst) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
  end

  // Measurement FSM with accumulators and registered result outputs.
  always_ff @(posedge pwm_clk or negedge pwm_rst) begin
    if (!pwm_rst) begin
      state            <= IDLE;
      s_prev           <= 1'b0;
      remain           <= '0;
      high_acc         <= '0;
      low_acc          <= '0;
      rise_acc         <= '0;
      per_cnt          <= '0;
      per_acc          <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.high_cnt     <= '0;
      bus.low_cnt      <= '0;
      bus.rise_cnt     <= '0;
      bus.period       <= '0;
      bus.period_valid <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            high_acc <= '0;
            low_acc  <= '0;
            rise_acc <= '0;
            per_cnt  <= '0;
            per_acc  <= '0;
            remain   <= bus.window;
            s_prev   <= s;
            bus.busy <= 1'b1;
            state    <= (bus.window == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (s) high_acc <= high_acc + ONE;
          else   low_acc  <= low_acc + ONE;
          if (s && !s_prev) begin
            rise_acc <= rise_acc + ONE;
            // The counter is only a complete period once an earlier edge exists.
            if (rise_acc != '0) per_acc <= per_cnt;
            per_cnt <= ONE;
          end else if (per_cnt != '1) begin
            per_cnt <= per_cnt + ONE;
          end
          s_prev <= s;
          remain <= remain - ONE;
          if (remain == ONE) state <= DONE;
        end
        DONE: begin
          bus.high_cnt     <= high_acc;
          bus.low_cnt      <= low_acc;
          bus.rise_cnt     <= rise_acc;
          bus.period       <= per_acc;
          bus.period_valid <= (rise_acc >= TWO);
          bus.done         <= 1'b1;
          bus.busy         <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Single-clock PWM capture unit that measures an incoming PWM waveform over a programmable window of `pwm_clk` cycles. It reports high-cycle count, low-cycle count, rising-edge count and the last complete rising-to-rising period. It sits in the PWM clock domain as the receive-side counterpart of the PWM generator channels. It is used for on-chip loopback self-check of `pwm_o_*` and for capturing external PWM sensors.

## Interface

- `CNT_W`, default 16: width of the window, counter and result fields.
- `SYNC_STAGES`, default 2: flop stages in the `pwm_i` synchronizer (minimum 2).

Ports:

- `pwm_clk` in 1: sole clock, rising edge.
- `pwm_rst` in 1: asynchronous active-low reset.
- `pwm_i` in 1: PWM input, asynchronous to `pwm_clk`.
- `start` in 1: level-sampled request to begin a measurement.
- `window` in CNT_W: measurement length in cycles, sampled with `start`.
- `busy` out 1: measurement in progress.
- `done` out 1: one-cycle pulse when results update.
- `high_cnt` out CNT_W: sampled-high cycles in the last window.
- `low_cnt` out CNT_W: sampled-low cycles in the last window.
- `rise_cnt` out CNT_W: rising edges detected in the last window.
- `period` out CNT_W: cycles between the last two rising edges in the window.
- `period_valid` out 1: high when `rise_cnt` ≥ 2.

## Operation

- **Synchronizer**
  - `pwm_i` passes through `SYNC_STAGES` flops; the last stage is `s`.
  - All counting uses `s` only.
  - Synchronizer flops reset to 0.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 with `window`≠0:
    - load `remain`=`window`;
    - clear the high, low, rise and period accumulators;
    - load `s_prev`=`s`, so no false edge is seen at entry;
    - go to RUN.
  - `start`=1 with `window`=0: go to DONE with all accumulators zero.
- **RUN**, every cycle:
  - `s`=1: increment high accumulator; otherwise increment low accumulator.
  - Rising edge (`s` & ~`s_prev`):
    - increment rise accumulator;
    - if this is not the first edge, copy the running period counter to the period result;
    - restart the period counter at 1.
  - Otherwise the period counter increments, saturating at 2^CNT_W−1.
  - `s_prev`<=`s`; `remain` decrements.
  - When `remain`==1, go to DONE.
- **DONE**, one cycle:
  - transfer accumulators to the output registers;
  - assert `done`;
  - return to IDLE.
- **Invariants**
  - `high_cnt`+`low_cnt`==`window` for every completed measurement; no overflow is possible.
  - `period` is 0 and `period_valid` is 0 when fewer than 2 edges occur.
- **Boundary conditions**
  - `start` in RUN or DONE is ignored; no queuing.
  - `window`=2^CNT_W−1 is legal, and the result equals the full count.
- **Reset**, asserted at any time including mid-RUN:
  - FSM goes to IDLE;
  - `busy`=0, `done`=0;
  - all result outputs are 0 and `period_valid`=0.

## Timing

- `start` is sampled at edge T in IDLE.
- RUN samples `s` at edges T+1 … T+W, where W=`window`.
- DONE occupies the cycle after edge T+W. `done`=1 and the new results are visible after edge T+W+1.
- Total latency from `start` to `done` is W+1 cycles, or 1 cycle for W=0.
- `busy`=1 from after T through the DONE cycle inclusive.
- `start` is accepted again the cycle after `done`.
- Input latency: a `pwm_i` change setting up before edge k appears in `s` after edge k+SYNC_STAGES−1.
- Results hold their value until the next `done` or reset.

## Test plan

- **Constant high:** `pwm_i`=1 held, `window`=256 → `done` 257 cycles after `start`; `high_cnt`=256, `low_cnt`=0, `rise_cnt`=0, `period_valid`=0.
- **Square wave, 16-cycle period, 4 high:**
  - Stimulus: phase aligned so the first RUN sample of `s` is the first low cycle; `window`=256.
  - Expected: `high_cnt`=64, `low_cnt`=192, `rise_cnt`=16, `period`=16, `period_valid`=1.
- **Zero window:** `window`=0 → `done` on the next cycle; all results 0; `busy` high for 1 cycle only.
- **Start while busy:** pulse `start` mid-RUN with a different `window` → ignored; results match the original window; exactly one `done` pulse.
- **Reset mid-run:** assert `pwm_rst` low 100 cycles into a 256-cycle window → `busy`=0, results 0, no `done`. Release reset and restart with `window`=256 → normal results.
- **Full-width window:** constant low, `window`=65535 → `low_cnt`=65535, `high_cnt`=0, `done` after 65536 cycles.
